// File: rtl/id_issue_ctrl.sv
// Issue sequencer between the instruction queue and decode: pops the queue and buffers bundles.
// Latency: iq_pop at cycle N gives ds_valid at N+2 into an empty buffer; registered outputs only.
// Backpressure: credit-limited pops (buffer + in-flight <= 2); ds_* hold while !ds_ready.
module id_issue_ctrl #(
   parameter int WAY       = 2,
   parameter int BUF_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            iq_status,
   output logic                  iq_pop,
   input  logic                  iq_resp,
   input  logic [WAY-1:0][31:0]  iq_rdata,
   input  logic [WAY-1:0][31:0]  iq_pc,
   input  logic                  flush,
   input  logic                  ds_ready,
   output logic                  ds_valid,
   output logic [WAY-1:0][31:0]  ds_inst,
   output logic [WAY-1:0][31:0]  ds_pc,
   output logic [31:0]           stall_cnt
);

   typedef enum logic {RUN, DRAIN} state_t;

   localparam logic [2:0] DEPTH = 3'(BUF_DEPTH);

   state_t state, state_nxt;

   // Two-entry circular bundle buffer; one-bit pointers since depth is fixed at two.
   logic [WAY-1:0][31:0] buf_inst [BUF_DEPTH];
   logic [WAY-1:0][31:0] buf_pc   [BUF_DEPTH];
   logic                 head;
   logic                 tail;
   logic [1:0]           count;
   logic                 inflight;

   logic                 q_has_data;
   logic                 hs;
   logic                 enq;
   logic                 deq;
   logic [2:0]           occ_after;

   // Status 01 (empty) and the reserved 11 both mean nothing to pop.
   assign q_has_data = !iq_status[0];

   assign ds_valid = (count != 2'd0);
   assign ds_inst  = buf_inst[head];
   assign ds_pc    = buf_pc[head];

   // Handshake as seen by the credit check; a flush cancels its effect on the buffer.
   assign hs  = ds_valid && ds_ready;
   assign deq = hs && !flush;
   assign enq = iq_resp && inflight && (state == RUN) && !flush;

   // Occupancy the buffer would have once the pending response lands, after this cycle's dequeue.
   assign occ_after = {1'b0, count} + {2'b00, inflight} - {2'b00, hs};

   // State register for the flush/drain sequencer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and pop request; a flush always suppresses the pop for its own cycle.
   always_comb begin
      state_nxt = state;
      iq_pop    = 1'b0;
      if (flush) begin
         state_nxt = inflight ? DRAIN : RUN;
      end else begin
         case (state)
            RUN: begin
               iq_pop = !rst && q_has_data && (occ_after < DEPTH);
            end
            DRAIN: begin
               state_nxt = RUN;
            end
            default: begin
               state_nxt = RUN;
            end
         endcase
      end
   end

   // Buffer pointers, occupancy and in-flight tracking; flush empties the buffer outright.
   always_ff @(posedge clk) begin
      if (rst) begin
         head     <= 1'b0;
         tail     <= 1'b0;
         count    <= 2'd0;
         inflight <= 1'b0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            buf_inst[i] <= '0;
            buf_pc[i]   <= '0;
         end
      end else begin
         inflight <= iq_pop;
         if (flush) begin
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
         end else begin
            if (enq) begin
               buf_inst[tail] <= iq_rdata;
               buf_pc[tail]   <= iq_pc;
               tail           <= ~tail;
            end
            if (deq) begin
               head <= ~head;
            end
            case ({enq, deq})
               2'b10:   count <= count + 2'd1;
               2'b01:   count <= count - 2'd1;
               default: count <= count;
            endcase
         end
      end
   end

   // Saturating count of cycles where a bundle is offered but decode refuses it.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (ds_valid && !ds_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end

endmodule

// File: doc/id_issue_ctrl.md
Name: id_issue_ctrl

Overview:
- Sequencer between the instruction queue and the decode/rename/dispatch stage.
- Issues instruction-queue pops and absorbs the queue's one-cycle read latency with a 2-entry bundle buffer.
- Presents WAY-wide fetch bundles to decode with a valid/ready handshake.
- Squashes buffered and in-flight bundles on a backend flush (branch mispredict).

Parameters:
WAY, 2, instructions per bundle (matches superscalar width in rv32i_types)
BUF_DEPTH, 2, bundle buffer entries (fixed at 2; 1 output slot + 1 skid slot)

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous active-high reset
iq_status  input  2  instruction queue status: 2'b01 empty, 2'b10 full, 2'b00 partial, 2'b11 reserved (treated as empty)
iq_pop  output  1  pop request to instruction queue (combinational)
iq_resp  input  1  pop data valid, exactly one cycle after an accepted iq_pop
iq_rdata  input  [WAY-1:0] x 32  bundle instructions, valid with iq_resp
iq_pc  input  [WAY-1:0] x 32  bundle PCs, valid with iq_resp
flush  input  1  backend squash (mispredict/redirect)
ds_ready  input  1  decode/rename accepts a bundle this cycle (inverse of back_pressure)
ds_valid  output  1  bundle at buffer head is valid
ds_inst  output  [WAY-1:0] x 32  head bundle instructions
ds_pc  output  [WAY-1:0] x 32  head bundle PCs
stall_cnt  output  32  perf counter: cycles with ds_valid && !ds_ready

Behaviour:
- Reset (rst=1 at posedge):
  - buffer count=0, inflight=0, state=RUN.
  - ds_valid=0, ds_inst/ds_pc=0, stall_cnt=0.
  - iq_pop=0 while rst high.
- Buffer: 2-entry circular FIFO of {inst[WAY], pc[WAY]}; head drives ds_*; ds_valid = (count!=0).
- Credit rule: iq_pop = (state==RUN) && !flush && iq_status∉{01,11} && (count + inflight − deq) < 2, where deq = ds_valid && ds_ready.
  - Throughput: 1 bundle/cycle when ds_ready is held high.
  - Buffer never overflows.
- inflight (0..1) = iq_pop registered; a response is expected the next cycle.
- iq_resp without inflight=1 is ignored. A missing iq_resp when inflight=1 clears inflight, no enqueue.
- Enqueue on iq_resp && inflight && state==RUN && !flush. Enqueue and dequeue in the same cycle: count unchanged, pointers both advance.
- Data latency: iq_pop at cycle N → ds_valid at cycle N+2 if the buffer was empty (capture at N+1 edge). No combinational path iq_rdata→ds_*.
- Dequeue: handshake completes when ds_valid && ds_ready at posedge; head pointer advances. ds_* hold stable while ds_valid && !ds_ready.
- FSM:
  - RUN: normal operation.
  - flush=1 in any state: clear buffer (count=0, ds_valid=0 next cycle), iq_pop=0 that cycle. Next state DRAIN if inflight=1, else RUN.
  - DRAIN: iq_pop=0; the single pending iq_resp is discarded; → RUN next cycle.
  - Flush during DRAIN: stays DRAIN for one more cycle only if inflight=1, else RUN.
  - Flush has priority over enqueue and dequeue in the same cycle. The bundle at the head is not considered accepted.
- stall_cnt: increments when ds_valid && !ds_ready; saturates at 32'hFFFF_FFFF; not cleared by flush.
- ds_inst/ds_pc contents are don't-care when ds_valid=0. Verification checks them only with ds_valid.

Test Plan:
- Reset then iq_status=00, ds_ready=1, queue returns inst 0x00000013/0x00100093 at pc 0x1eceb000/0x1eceb004 → iq_pop high from cycle 1; ds_valid high cycle 3 with those values; one bundle per cycle thereafter.
- Back-pressure: ds_ready=0 for 5 cycles with a streaming queue → buffer fills to 2; iq_pop drops after 2 bundles captured; ds_* stable; stall_cnt=5; on ds_ready=1, bundles drain in order with none lost or duplicated.
- Empty queue: iq_status=01 → iq_pop=0, ds_valid falls after the buffer drains; iq_status=11 behaves identically.
- Flush with inflight=1 and count=2 → next cycle ds_valid=0, state DRAIN; the stale iq_resp data (0xDEADBEEF) never appears on ds_inst; iq_pop resumes the cycle after.
- Simultaneous flush, ds_ready=1 and iq_resp → no dequeue counted, no enqueue, count=0.
- rst asserted mid-stream with count=2, inflight=1 → all outputs zero next cycle; the iq_resp arriving after reset is ignored.
